// File: rtl/common_pkg.sv
// Shared CBus transaction types used by masters, arbiters and responders.
// Request/response bundles plus burst length and burst type encodings.
package common;

  typedef logic [3:0] mlen_t;

  localparam mlen_t MLEN1  = 4'd0;
  localparam mlen_t MLEN2  = 4'd1;
  localparam mlen_t MLEN4  = 4'd3;
  localparam mlen_t MLEN8  = 4'd7;
  localparam mlen_t MLEN16 = 4'd15;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_type_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    logic [63:0]     addr;
    logic [7:0]      strobe;
    logic [63:0]     data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_ram_array.sv
// Single-port 2^AW x 64 storage with byte write enables.
// Read port is registered and returns zero when not enabled.
module cbus_ram_array #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          re,
  input  logic [7:0]    we,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
    rdata <= re ? mem[addr] : 64'h0;
  end

endmodule

// File: rtl/cbus_ram.sv
// CBus memory responder: accepts one request, answers after LATENCY
// cycles with single or burst beats generated from the latched request.
import common::*;

module cbus_ram #(
  parameter int AW      = 16,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  function automatic logic [AW-1:0] wrap_mask(mlen_t len);
    logic [AW-1:0] m;
    m = {{(AW-4){1'b0}}, len};
    unique case (len)
      4'd1, 4'd3, 4'd7, 4'd15: return m;
      default:                 return '0;
    endcase
  endfunction

  state_t          st;
  logic [CW-1:0]   cnt;
  mlen_t           bc, blen;
  axi_burst_type_t bb;
  logic            wr, ready, last;
  logic [AW-1:0]   idx, wa;

  logic            idle, issue, iss_last, cwr;
  logic [AW-1:0]   cidx, nidx, msk, aaddr;
  mlen_t           cbc, clen;
  axi_burst_type_t cb;
  logic [7:0]      we;
  logic [63:0]     rdata;
  logic            unused_bits;

  // In IDLE the beat being issued comes straight from the request.
  assign idle     = (st == IDLE);
  assign cidx     = idle ? creq.addr[AW+2:3] : idx;
  assign cbc      = idle ? 4'd0 : bc;
  assign clen     = idle ? creq.len : blen;
  assign cb       = idle ? creq.burst : bb;
  assign cwr      = idle ? creq.is_write : wr;
  assign iss_last = (cbc == clen);

  always_comb begin
    issue = 1'b0;
    unique case (1'b1)
      idle:         issue = (LATENCY == 1);
      (st == WAIT): issue = (cnt == '0);
      (st == BURST): issue = 1'b1;
      default:      issue = 1'b0;
    endcase
    issue = issue & creq.valid & reset;
  end

  always_comb begin
    msk  = (cb == AXI_BURST_WRAP) ? wrap_mask(clen) : '0;
    nidx = cidx + 1'b1;
    if (cb == AXI_BURST_FIXED) nidx = cidx;
    else if (msk != '0) nidx = (cidx & ~msk) | ((cidx + 1'b1) & msk);
  end

  // Reads are addressed one cycle ahead; writes land in the beat cycle.
  assign aaddr = (ready && wr) ? wa : cidx;
  assign we    = (ready && wr && creq.valid && reset) ? creq.strobe : 8'h00;

  cbus_ram_array #(.AW(AW)) u_array (
    .clk   (clk),
    .addr  (aaddr),
    .re    (issue & ~cwr),
    .we    (we),
    .wdata (creq.data),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      st    <= IDLE;
      ready <= 1'b0;
      last  <= 1'b0;
      cnt   <= '0;
      bc    <= '0;
      blen  <= '0;
      bb    <= AXI_BURST_INCR;
      wr    <= 1'b0;
      idx   <= '0;
      wa    <= '0;
    end else begin
      ready <= issue;
      last  <= issue & iss_last;
      if (issue) wa <= cidx;
      unique case (st)
        IDLE: if (creq.valid) begin
          wr   <= creq.is_write;
          blen <= creq.len;
          bb   <= creq.burst;
          cnt  <= CW'(LATENCY - 2);
          if (issue) begin
            bc  <= 4'd1;
            idx <= nidx;
            st  <= iss_last ? DONE : BURST;
          end else begin
            bc  <= '0;
            idx <= cidx;
            st  <= WAIT;
          end
        end
        WAIT: begin
          if (!creq.valid) st <= IDLE;
          else if (issue) begin
            bc  <= bc + 4'd1;
            idx <= nidx;
            st  <= iss_last ? DONE : BURST;
          end else cnt <= cnt - 1'b1;
        end
        BURST: begin
          if (!creq.valid) st <= IDLE;
          else begin
            bc  <= bc + 4'd1;
            idx <= nidx;
            if (iss_last) st <= DONE;
          end
        end
        DONE: if (!creq.valid) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  assign cresp = {ready, last, rdata};

  assign unused_bits = ^{creq.size, creq.addr[63:AW+3], creq.addr[2:0]};

endmodule

// File: tb/tb_cbus_ram.sv
// Bench for cbus_ram: directed steps plus random bursts checked
// against a word-array model with spec-level address arithmetic.
module tb_cbus_ram;
  import common::*;

  localparam int AW = 16;
  localparam int L  = 2;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  cbus_ram #(.AW(AW), .LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .creq  (creq),
    .cresp (cresp)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int tn   = 0;
  logic [63:0] mm [int];
  logic [63:0] wd [16];
  logic [7:0]  sb [16];
  logic [63:0] rd [16];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int bidx(input logic [63:0] addr, input int len,
                              input axi_burst_type_t b, input int i);
    int base, n;
    base = int'(addr[AW+2:3]);
    n = len + 1;
    if (b == AXI_BURST_FIXED) return base;
    if (b == AXI_BURST_WRAP && (n == 2 || n == 4 || n == 8 || n == 16))
      return (base / n) * n + (base % n + i) % n;
    return (base + i) % (1 << AW);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o,
                                        input logic [63:0] n,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int k = 0; k < 8; k++) if (s[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One transaction; abort >= 0 drops valid in that beat's cycle.
  task automatic txn(input bit wr, input logic [63:0] addr, input int len,
                     input axi_burst_type_t b, input int abort);
    int last_c;
    tn++;
    last_c = (abort >= 0) ? L + abort + 1 : L + len + 1;
    creq          = '0;
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.size     = MSIZE8;
    creq.addr     = addr;
    creq.len      = mlen_t'(len);
    creq.burst    = b;
    creq.data     = wd[0];
    creq.strobe   = sb[0];
    @(negedge clk);
    chk($sformatf("t%0d accept_rdy", tn), {63'b0, cresp.ready}, 64'd0);
    step;
    for (int c = 1; c <= last_c; c++) begin
      int i;
      bit beat;
      logic [63:0] ed;
      i = c - L;
      beat = (i >= 0 && i <= len && (abort < 0 || i <= abort));
      if (abort >= 0 && i >= abort) creq.valid = 1'b0;
      if (c == L + len + 1) creq.valid = 1'b0;
      if (beat) begin
        creq.data   = wd[i];
        creq.strobe = sb[i];
      end
      ed = 64'h0;
      if (beat && !wr) ed = mm[bidx(addr, len, b, i)];
      @(negedge clk);
      chk($sformatf("t%0d c%0d ready", tn, c), {63'b0, cresp.ready},
          {63'b0, beat});
      chk($sformatf("t%0d c%0d last", tn, c), {63'b0, cresp.last},
          {63'b0, beat && i == len});
      chk($sformatf("t%0d c%0d data", tn, c), cresp.data, ed);
      if (beat && !wr) rd[i] = cresp.data;
      if (beat && wr && creq.valid) begin
        int a;
        a = bidx(addr, len, b, i);
        mm[a] = merge(mm.exists(a) ? mm[a] : 64'h0, wd[i], sb[i]);
      end
      step;
    end
    creq.valid = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    creq          = '0;
    creq.valid    = 1'b1;
    creq.len      = MLEN4;
    creq.burst    = AXI_BURST_INCR;
    creq.addr     = 64'h100;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rst%0d", r), {cresp.ready, cresp.last, 62'b0}, 64'd0);
      chk($sformatf("rst%0d data", r), cresp.data, 64'd0);
    end
    reset      = 1'b1;
    creq.valid = 1'b0;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d", r), {63'b0, cresp.ready}, 64'd0);
    end
    step;

    wd[0] = 64'h1122334455667788;
    sb[0] = 8'hFF;
    txn(1, 64'h80, 0, AXI_BURST_INCR, -1);
    txn(0, 64'h80, 0, AXI_BURST_INCR, -1);
    chk("rd80", rd[0], 64'h1122334455667788);

    wd[0] = 64'hAAAAAAAAAAAAAAAA;
    sb[0] = 8'h0F;
    txn(1, 64'h80, 0, AXI_BURST_INCR, -1);
    txn(0, 64'h80, 0, AXI_BURST_INCR, -1);
    chk("rd80_part", rd[0], 64'h11223344AAAAAAAA);

    for (int i = 0; i < 4; i++) begin
      wd[i] = 64'(i);
      sb[i] = 8'hFF;
    end
    txn(1, 64'h100, 3, AXI_BURST_INCR, -1);
    txn(0, 64'h100, 3, AXI_BURST_INCR, -1);
    for (int i = 0; i < 4; i++) chk($sformatf("incr%0d", i), rd[i], 64'(i));
    txn(0, 64'h110, 3, AXI_BURST_WRAP, -1);
    chk("wrap0", rd[0], 64'd2);
    chk("wrap1", rd[1], 64'd3);
    chk("wrap2", rd[2], 64'd0);
    chk("wrap3", rd[3], 64'd1);

    for (int i = 0; i < 4; i++) wd[i] = 64'hA0 + 64'(i);
    txn(1, 64'h100, 3, AXI_BURST_INCR, 2);
    txn(0, 64'h100, 3, AXI_BURST_INCR, -1);
    chk("abort0", rd[0], 64'hA0);
    chk("abort1", rd[1], 64'hA1);
    chk("abort2", rd[2], 64'd2);
    chk("abort3", rd[3], 64'd3);

    creq          = '0;
    creq.valid    = 1'b1;
    creq.addr     = 64'h100;
    creq.burst    = AXI_BURST_INCR;
    step;
    reset = 1'b0;
    step;
    reset      = 1'b1;
    creq.valid = 1'b0;
    @(negedge clk);
    chk("wrst rdy", {cresp.ready, cresp.last, 62'b0}, 64'd0);
    chk("wrst data", cresp.data, 64'd0);
    step;
    @(negedge clk);
    chk("wrst rdy2", {63'b0, cresp.ready}, 64'd0);
    step;
    txn(0, 64'h100, 0, AXI_BURST_INCR, -1);
    chk("after_wrst", rd[0], 64'hA0);

    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom};
      sb[i] = 8'hFF;
    end
    txn(1, 64'h7FFF0, 3, AXI_BURST_INCR, -1);
    txn(0, 64'h7FFF0, 3, AXI_BURST_INCR, -1);
    chk("topwrap", rd[2], wd[2]);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 16; i++) begin
        wd[i] = {$urandom, $urandom};
        sb[i] = 8'hFF;
      end
      txn(1, 64'h200 + 64'(k) * 64'd128, 15, AXI_BURST_INCR, -1);
    end

    for (int n = 0; n < 40; n++) begin
      bit w;
      int len;
      logic [63:0] a;
      axi_burst_type_t b;
      w   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(0, 15));
      a   = 64'($urandom_range(16'h40, 16'h8F)) << 3;
      b   = axi_burst_type_t'($urandom_range(0, 2));
      for (int i = 0; i < 16; i++) begin
        wd[i] = {$urandom, $urandom};
        sb[i] = 8'($urandom);
      end
      txn(w, a, len, b, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/cbus_ram.md
# cbus_ram

Memory-side responder for the CBus: the slave end that a `CBusArbiter` `oreq`/`oresp` pair terminates into. It accepts one `cbus_req_t` transaction at a time and answers with a single-beat or burst response on `cbus_resp_t`. Timing is parameterizable. It serves as the simulation main memory behind the I-cache/D-bus path and as the reference responder for arbiter and cache benches.

## Interface
- `AW`, 16: word-address bits. Memory holds 2^AW 64-bit words, indexed by `addr[AW+2:3]`.
- `LATENCY`, 2: cycles from request acceptance to first beat. Legal range is ≥1.
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-low.
- `creq` input `cbus_req_t`: `valid`, `is_write`, `size`, `addr`, `strobe[7:0]`, `data[63:0]`, `len` (`mlen_t`, beats-1), `burst` (`AXI_BURST_FIXED/INCR/WRAP`).
- `cresp` output `cbus_resp_t`: `ready`, `last`, `data[63:0]`.

## Operation
- FSM states:
  - `IDLE`: when `creq.valid`=1, latch `is_write`, word index, `len`, `burst`. Clear beat counter. Load latency counter. Go to `WAIT`.
  - `WAIT`: count down. The state ends so that the first beat lands exactly `LATENCY` cycles after the acceptance cycle. Go to `BURST`.
  - `BURST`: one beat per cycle with `ready`=1; there is no master backpressure. `last`=1 on beat `len`. After the last beat, go to `DONE`.
  - `DONE`: `ready`=0. Return to `IDLE` on the first cycle `creq.valid`=0. This gives at least one dead cycle between transactions, so a stale `valid` is never re-accepted.
- Address sequencing, per beat, modulo 2^AW:
  - `INCR`: index+1.
  - `FIXED`: index unchanged.
  - `WRAP`: index+1 within a block of `len+1` words aligned to (len+1)·8 bytes. `len+1` must be 2/4/8/16; otherwise the burst is treated as `INCR`.
- Read: `cresp.data` is the full 64-bit word at the current index. `size` is ignored.
- Write:
  - On each beat cycle, sample `creq.data`/`creq.strobe`.
  - At that clock edge, write byte k iff `strobe[k]`.
  - `size` is ignored; strobe alone governs.
- `creq.valid` dropping in `WAIT`/`BURST`: abort to `IDLE` next cycle, `ready`=0. Writes of already-completed beats persist.
- Array contents are not affected by reset and are undefined until written.
- `cresp.data` outside read beats: 0.

## Timing
- Reset value of every output: `ready`=0, `last`=0, `data`=0. State is `IDLE`.
- Acceptance at cycle t (valid sampled in `IDLE`):
  - Beat i has `ready`=1 at cycle t+LATENCY+i, i=0..len.
  - `last` is high only at i=len.
- Read data is valid in the same cycle as its `ready`, and is driven from registers (no combinational path from `creq`).
- Write beat i data must be stable on `creq` during cycle t+LATENCY+i.
- Minimum issue-to-issue spacing: LATENCY+len+2 cycles.
- Reset mid-operation: next cycle all outputs are 0 and the FSM is in `IDLE`. The pending beat is not written.
- Read-after-write to the same word in back-to-back transactions returns the new data.

## Structure
- `cbus_req_t`, `cbus_resp_t`, `mlen_t`, `axi_burst_type_t`, `msize_t` come from package `common`; nothing new is added there.
- Local state enum and the wrap-mask helper function stay in-module.
- Sub-module `cbus_ram_array`: a single-port, 2^AW×64 array with 8 byte-write-enables and a registered read port. `cbus_ram` contains the FSM, counters and address generator.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `creq.valid`=1 → `ready`/`last`/`data` all 0; no transaction is accepted until `reset`=1.
- Single write then read:
  - Write 0x1122334455667788 to 0x80, strobe 0xFF, `MLEN1`, LATENCY=2 → `ready`=`last`=1 exactly 2 cycles after acceptance.
  - Read 0x80 → `data`=0x1122334455667788 with `last`=1.
- Partial strobe: after the above, write 0xAAAAAAAAAAAAAAAA to 0x80 with strobe 0x0F → read returns 0x11223344AAAAAAAA.
- INCR read burst: words 0x100..0x118 preloaded with 0,1,2,3; read 0x100, `MLEN4`, `INCR` → beats 0,1,2,3 on consecutive cycles; `last` only on the 4th beat.
- WRAP read burst: same data, read 0x110, `MLEN4`, `WRAP` → beats 2,3,0,1.
- Abort/reset mid-burst:
  - Drop `valid` after beat 1 of a 4-beat write → only beats 0–1 are written; `ready`=0 next cycle.
  - Separately, assert `reset`=0 during `WAIT` → no beat is issued; a new request afterwards is served normally.
